// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory read port and the F/D payload.
interface fetch_stage_if #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IMEM_ADDR_W = 12
);
  localparam int unsigned INSN_W = 32;

  logic [IMEM_ADDR_W-1:0] address_imem;
  logic [INSN_W-1:0]      q_imem;
  logic [PC_W-1:0]        fd_pc;
  logic [INSN_W-1:0]      fd_insn;
  logic                   fd_valid;

  // Fetch stage side: drives the imem address and the decode payload
  modport master (
    output address_imem,
    input  q_imem,
    output fd_pc,
    output fd_insn,
    output fd_valid
  );

  // Memory/decode side: returns imem data and consumes the payload
  modport slave (
    input  address_imem,
    output q_imem,
    input  fd_pc,
    input  fd_insn,
    input  fd_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency imem, and
// presents a registered {pc, insn, valid} triple to decode. A skid register
// captures the in-flight imem response when a stall arrives so it is neither
// lost nor duplicated. Redirects flush everything and inject bubbles.
// Optional feature macro: FETCH_PERF_CNT_EN enables the stall/flush counters;
// when undefined the counter ports are tied to 0.
module fetch_stage #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IMEM_ADDR_W = 12,
  parameter logic [31:0] NOP_INSN    = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_in,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flushes,
  fetch_stage_if.master      bus
);

  localparam int unsigned INSN_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic [PC_W-1:0]   pc_reg;
  logic              resp_valid;
  logic [PC_W-1:0]   resp_pc;
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INSN_W-1:0] skid_insn;
  logic [PC_W-1:0]   fd_pc_q;
  logic [INSN_W-1:0] fd_insn_q;
  logic              fd_valid_q;

  // Candidate decode payload for an unstalled, unredirected edge
  logic [PC_W-1:0]   fd_pc_nxt;
  logic [INSN_W-1:0] fd_insn_nxt;
  logic              fd_valid_nxt;

  // Next PC: redirect wins over stall, otherwise sequential (wraps naturally)
  always_comb begin
    pc_in = pc_reg + PC_W'(1);
    if (redirect) begin
      pc_in = redirect_pc;
    end else if (stall) begin
      pc_in = pc_reg;
    end
  end

  // Select what decode sees next: skid first, then the live imem response
  always_comb begin
    fd_pc_nxt    = resp_pc;
    fd_insn_nxt  = NOP_INSN;
    fd_valid_nxt = 1'b0;
    if (skid_valid) begin
      fd_pc_nxt    = skid_pc;
      fd_insn_nxt  = skid_insn;
      fd_valid_nxt = 1'b1;
    end else if (resp_valid) begin
      fd_pc_nxt    = resp_pc;
      fd_insn_nxt  = bus.q_imem;
      fd_valid_nxt = 1'b1;
    end
  end

  // PC, in-flight tracking, skid buffer and F/D register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg     <= '0;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_insn  <= '0;
      fd_pc_q    <= '0;
      fd_insn_q  <= NOP_INSN;
      fd_valid_q <= 1'b0;
    end else if (redirect) begin
      pc_reg     <= redirect_pc;
      resp_valid <= 1'b0;
      skid_valid <= 1'b0;
      fd_pc_q    <= redirect_pc;
      fd_insn_q  <= NOP_INSN;
      fd_valid_q <= 1'b0;
    end else if (stall) begin
      resp_valid <= 1'b0;
      if (resp_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= resp_pc;
        skid_insn  <= bus.q_imem;
      end
    end else begin
      pc_reg     <= pc_reg + PC_W'(1);
      resp_valid <= 1'b1;
      resp_pc    <= pc_reg;
      skid_valid <= 1'b0;
      fd_pc_q    <= fd_pc_nxt;
      fd_insn_q  <= fd_insn_nxt;
      fd_valid_q <= fd_valid_nxt;
    end
  end

  assign bus.address_imem = pc_reg[IMEM_ADDR_W-1:0];
  assign bus.fd_pc        = fd_pc_q;
  assign bus.fd_insn      = fd_insn_q;
  assign bus.fd_valid     = fd_valid_q;
  assign pc_out           = pc_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating stall-cycle and redirect counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (redirect) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (stall) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cycles = stall_cnt;
  assign perf_flushes      = flush_cnt;
`else
  assign perf_stall_cycles = CNT_W'(0);
  assign perf_flushes      = CNT_W'(0);
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined processor, instantiated inside my_processor ahead of the lfd (F/D) latch.
- Owns the PC register and drives the synchronous instruction memory (1-cycle read latency).
- Feeds decode a registered {pc, insn, valid} triple.
- Honours the hazard unit's stall and the execute stage's branch/jump redirect; a skid register keeps any in-flight imem response across a stall.

Parameters:
PC_W, 32, PC width; PC counts instructions (word index), +1 per fetch
IMEM_ADDR_W, 12, imem address width; address_imem = pc_reg[IMEM_ADDR_W-1:0]
NOP_INSN, 32'h00000000, instruction value injected as a bubble

Ports:
clock  in  1  processor clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
stall  in  1  hold request from hazard unit (dhc); freeze fetch and FD outputs
redirect  in  1  taken branch/jump from execute; flush and load redirect_pc
redirect_pc  in  PC_W  target PC, valid when redirect=1
address_imem  out  IMEM_ADDR_W  imem read address, combinational from pc_reg
q_imem  in  32  imem data for the address presented on the previous cycle
pc_out  out  PC_W  current pc_reg (probe)
pc_in  out  PC_W  next-cycle pc_reg value, combinational (probe)
fd_pc  out  PC_W  PC of instruction presented to decode
fd_insn  out  32  instruction presented to decode
fd_valid  out  1  fd_insn is a real fetched instruction (0 = bubble)
perf_stall_cycles  out  32  stall-cycle counter (optional feature)
perf_flushes  out  32  redirect counter (optional feature)

Behaviour:
- Internal regs: pc_reg, resp_valid, resp_pc, skid_valid, skid_pc, skid_insn, plus the fd_* outputs.
- Reset (reset=0, asynchronous, no clock needed): pc_reg=0, resp_valid=0, resp_pc=0, skid_valid=0, skid_pc=0, skid_insn=0, fd_pc=0, fd_insn=NOP_INSN, fd_valid=0, perf counters=0.
- Mid-operation reset discards in-flight and skid data; the first fetch after release is PC 0.
- Priority each edge: redirect > stall > normal.
- Normal (redirect=0, stall=0):
  - pc_reg <= pc_reg+1; resp_valid <= 1; resp_pc <= pc_reg.
  - FD <= skid if skid_valid, else {resp_pc, q_imem, 1} if resp_valid, else {resp_pc, NOP_INSN, 0}.
  - skid_valid <= 0.
- Stall (redirect=0, stall=1):
  - pc_reg, fd_* hold; resp_valid <= 0 (no new request).
  - If resp_valid=1 and skid_valid=0: skid <= {resp_pc, q_imem}, skid_valid <= 1.
  - Multi-cycle stall: skid holds its contents; the imem response is never lost or duplicated.
- Redirect (any stall value):
  - pc_reg <= redirect_pc; resp_valid <= 0; skid_valid <= 0.
  - fd_valid <= 0; fd_insn <= NOP_INSN; fd_pc <= redirect_pc.
- Redirect latency: redirect sampled at edge k; target issued to imem during cycle k..k+1; fd_valid=1 with fd_pc=redirect_pc after edge k+2, giving exactly 2 bubble cycles.
- Reset-release latency: fd_valid first rises after the 2nd rising edge following release, with fd_pc=0.
- pc_in = redirect ? redirect_pc : stall ? pc_reg : pc_reg+1.
- PC arithmetic is modulo 2^PC_W: pc_reg=all-ones wraps to 0.
- address_imem truncates pc_reg, so the imem address wraps at 2^IMEM_ADDR_W.
- Throughput: one valid instruction per cycle with no stall or redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_stall_cycles increments on each edge with stall=1 and redirect=0.
  - perf_flushes increments on each edge with redirect=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: both ports present and tied to 0; no counter flops.

Test Plan:
- Reset: imem[i]=i+100, release reset, run 5 edges -> edges 2..5 give fd_valid=1, fd_pc=0,1,2,3, fd_insn=100,101,102,103; pc_out=5.
- Stall: stall=1 for 3 cycles while fd_pc=2 -> fd_pc stays 2 and pc_out holds. On release: fd_pc=3 (insn 103, from skid), then 4, 5 with no gap or duplicate.
- Redirect: redirect=1, redirect_pc=40 at edge k -> fd_valid=0 after edges k, k+1. After k+2: fd_pc=40, fd_insn=140. Next edge: fd_pc=41. If FETCH_PERF_CNT_EN, perf_flushes=1.
- Simultaneous: stall=1 and redirect=1, redirect_pc=10 while skid is full -> skid discarded; fd_pc=10 appears 2 edges later; the stale instruction is never presented.
- Wrap: redirect_pc=32'hFFFFFFFF -> fd_pc sequence FFFFFFFF, 0, 1; address_imem sequence FFF, 000, 001.
- Async reset mid-stall: drive reset=0 between clock edges -> fd_valid=0 and pc_out=0 immediately; after release the fetch sequence restarts at 0.
